// File: rtl/wb_stream.sv
// wb_stream: array of per-neuron weight/bias banks with a valid/ready row streamer.
// Every beat carries the same row from all banks; rows wrap modulo DEPTH.
module wb_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1025,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage carries no reset so loaded weights survive a mid-stream reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  rdata_q <= '0;
    else if (re)  rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

module wb_stream #(
  parameter int    N_BANKS   = 32,
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 1025,
  parameter int    ADDR_W    = 11,
  parameter string INIT_FILE = "",
  localparam int   BANK_W    = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W:0]           len,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_BANKS*DATA_W-1:0] out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done,
  input  logic                      wr_en,
  input  logic [BANK_W-1:0]         wr_bank,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      wr_err
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic                valid_q, valid_d, last_q, last_d;
  logic                done_q, done_d, wr_err_q, wr_err_d;
  logic                ren, wr_ok;
  logic [N_BANKS-1:0][DATA_W-1:0] rows;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    remaining_d = remaining_q;
    valid_d     = valid_q;
    last_d      = last_q;
    done_d      = 1'b0;
    ren         = (state_q == S_RUN) && (!valid_q || out_ready);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            rd_addr_d   = (32'(base_addr) < DEPTH) ? base_addr : '0;
            remaining_d = len;
            state_d     = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (ren && remaining_q == (ADDR_W+1)'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (valid_q && out_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ren) begin
      valid_d     = 1'b1;
      last_d      = (remaining_q == (ADDR_W+1)'(1));
      rd_addr_d   = (rd_addr_q == ADDR_W'(DEPTH-1)) ? '0 : rd_addr_q + 1'b1;
      remaining_d = remaining_q - 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    wr_ok    = wr_en && (state_q == S_IDLE) && (32'(wr_bank) < N_BANKS) && (32'(wr_addr) < DEPTH);
    wr_err_d = wr_en && !wr_ok;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      remaining_q <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      remaining_q <= remaining_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
      wr_err_q    <= wr_err_d;
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    wb_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank (
      .clk    (clk),
      .resetn (resetn),
      .we     (wr_ok && (32'(wr_bank) == b)),
      .waddr  (wr_addr),
      .wdata  (wr_data),
      .re     (ren),
      .raddr  (rd_addr_q),
      .rdata  (rows[b])
    );
  end

  assign out_data  = rows;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign wr_err    = wr_err_q;
endmodule
